ex_mem_wb_pipe: RTL

Parametrised execute / memory-writeback back end for the 3-stage core. It takes decoded ID/EX operands and executes them through an ALU with EX/MEM forwarding, then holds the result in an EX/MEM register. From that register it drives a valid/ack data-memory port and the register-file write port. Versus the current fixed-width path it adds:
- XLEN and address-width generics
- a variable-latency memory handshake with pipeline stall
- operand forwarding
- registered branch resolution with self-squash
- a retire counter

---
 rtl/ex_pipe_pkg.sv | 25 ++
 rtl/ex_mem_wb_pipe_alu.sv | 52 +++++
 rtl/ex_mem_wb_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ex_pipe_pkg.sv
// Shared encodings for the execute / memory-writeback back end.
package ex_pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4
    } br_t;

endpackage

// File: rtl/ex_mem_wb_pipe_alu.sv
// Combinational ALU plus branch-condition evaluation for the EX stage.
module ex_alu
    import ex_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_t         op_i,
    input  br_t             br_i,
    output logic [XLEN-1:0] result_o,
    output logic            br_cond_o
);
    localparam int SH_W = $clog2(XLEN);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SH_W-1:0]        shamt;

    assign a_s   = a_i;
    assign b_s   = b_i;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = a_s >>> shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default:  result_o = '0;
        endcase
    end

    always_comb begin
        br_cond_o = 1'b0;
        case (br_i)
            BR_EQ:   br_cond_o = (a_i == b_i);
            BR_NE:   br_cond_o = (a_i != b_i);
            BR_LT:   br_cond_o = (a_s < b_s);
            BR_GE:   br_cond_o = !(a_s < b_s);
            default: br_cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX stage with forwarding feeding an EX/MEM register that drives a
// valid/ack data-memory port, register-file writeback and branch resolution.
module ex_mem_wb_pipe
    import ex_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_alu_src,
    input  alu_op_t          id_alu_op,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  br_t              id_br,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             flush,
    output logic             stall_out,
    output logic             dm_req,
    output logic             dm_we,
    output logic [DA_W-1:0]  dm_addr,
    output logic [XLEN-1:0]  dm_wdata,
    input  logic [XLEN-1:0]  dm_rdata,
    input  logic             dm_ack,
    output logic             wb_en,
    output logic [RA_W-1:0]  wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic [CNT_W-1:0] retired
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, brc_q, brc_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] alu_q, alu_d, sdata_q, sdata_d, tgt_q, tgt_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic            mem_op, stall, is_br, fwd_a, fwd_b, br_cond;
    logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res;

    // EX/MEM outputs
    assign mem_op    = valid_q && (mr_q || mw_q);
    assign stall     = mem_op && !dm_ack;
    assign stall_out = stall;
    assign dm_req    = mem_op;
    assign dm_we     = mem_op && mw_q;
    assign dm_addr   = alu_q[DA_W+1:2];
    assign dm_wdata  = sdata_q;
    assign wb_en     = valid_q && rw_q && (rd_q != '0) && (!mr_q || dm_ack);
    assign wb_rd     = rd_q;
    assign wb_data   = mr_q ? dm_rdata : alu_q;
    assign br_taken  = valid_q && brc_q;
    assign br_target = tgt_q;
    assign retired   = retired_q;

    // EX: wb_en already folds in valid, reg_write and rd != 0
    assign fwd_a   = wb_en && (rd_q == id_rs1);
    assign fwd_b   = wb_en && (rd_q == id_rs2);
    assign op_a    = fwd_a ? wb_data : id_rs1_data;
    assign rs2_fwd = fwd_b ? wb_data : id_rs2_data;
    assign op_b    = id_alu_src ? id_imm : rs2_fwd;
    assign is_br   = (id_br != BR_NONE);

    ex_alu #(.XLEN(XLEN)) u_alu (
        .a_i       (op_a),
        .b_i       (op_b),
        .op_i      (id_alu_op),
        .br_i      (id_br),
        .result_o  (alu_res),
        .br_cond_o (br_cond)
    );

    always_comb begin
        valid_d   = valid_q;
        rw_d      = rw_q;
        mr_d      = mr_q;
        mw_d      = mw_q;
        brc_d     = brc_q;
        rd_d      = rd_q;
        alu_d     = alu_q;
        sdata_d   = sdata_q;
        tgt_d     = tgt_q;
        retired_d = retired_q;
        if (valid_q && !stall && retired_q != CNT_MAX)
            retired_d = retired_q + CNT_W'(1);
        if (!stall) begin
            rd_d    = id_rd;
            alu_d   = alu_res;
            sdata_d = rs2_fwd;
            tgt_d   = id_pc + id_imm;
            if (flush || br_taken) begin
                valid_d = 1'b0;
                rw_d    = 1'b0;
                mr_d    = 1'b0;
                mw_d    = 1'b0;
                brc_d   = 1'b0;
            end else begin
                // branches are stripped of any writeback or memory side effect
                valid_d = id_valid;
                rw_d    = id_reg_write && !is_br;
                mr_d    = id_mem_read && !is_br;
                mw_d    = id_mem_write && !is_br;
                brc_d   = is_br && br_cond;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rw_q      <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            brc_q     <= 1'b0;
            rd_q      <= '0;
            alu_q     <= '0;
            sdata_q   <= '0;
            tgt_q     <= '0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rw_q      <= rw_d;
            mr_q      <= mr_d;
            mw_q      <= mw_d;
            brc_q     <= brc_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            sdata_q   <= sdata_d;
            tgt_q     <= tgt_d;
            retired_q <= retired_d;
        end
    end

endmodule
